// File: rtl/gpio_input_conditioner.sv
// Pad input conditioner for the GPIO PORTIN bus: per-pin synchronizer, tick-driven
// debounce filter and one-cycle rise/fall pulses aligned with the conditioned level.
module gpio_input_conditioner #(
  parameter int unsigned PORTWIDTH   = 16,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRE_WIDTH   = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [PORTWIDTH-1:0] PAD_IN,
  input  logic [PORTWIDTH-1:0] DB_EN,
  input  logic [CNT_WIDTH-1:0] DB_LIMIT,
  input  logic [PRE_WIDTH-1:0] PRESCALE,
  output logic [PORTWIDTH-1:0] PORTIN_O,
  output logic [PORTWIDTH-1:0] RISE,
  output logic [PORTWIDTH-1:0] FALL,
  output logic                 TICK
);

  localparam int unsigned CW1 = CNT_WIDTH + 1;

  logic [PORTWIDTH-1:0] sync_q [SYNC_STAGES];
  logic [PORTWIDTH-1:0] s_c;
  logic [PRE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                 tick_q, tick_d;
  logic [CNT_WIDTH-1:0] cnt_q [PORTWIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [PORTWIDTH];
  logic [PORTWIDTH-1:0] out_q, out_d;
  logic [PORTWIDTH-1:0] rise_q, rise_d;
  logic [PORTWIDTH-1:0] fall_q, fall_d;
  logic [CNT_WIDTH-1:0] eff_limit_c;

  assign s_c         = sync_q[SYNC_STAGES-1];
  assign eff_limit_c = (DB_LIMIT == '0) ? CNT_WIDTH'(1) : DB_LIMIT;

  // Plain flop chain; no logic between stages.
  always_ff @(posedge HCLK or negedge HRESETn) begin : sync_ff
    if (!HRESETn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= PAD_IN;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Prescaler: >= compare so a lowered PRESCALE wraps at once instead of running to overflow.
  always_comb begin : pre_comb
    tick_d = 1'b0;
    pcnt_d = pcnt_q + PRE_WIDTH'(1);
    if (pcnt_q >= PRESCALE) begin
      tick_d = 1'b1;
      pcnt_d = '0;
    end
  end

  // Debounce: a differing level must be seen on eff_limit consecutive ticks.
  always_comb begin : db_comb
    out_d = out_q;
    for (int i = 0; i < PORTWIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!DB_EN[i]) begin
        out_d[i] = s_c[i];
        cnt_d[i] = '0;
      end else if (s_c[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_q) begin
        if (CW1'(cnt_q[i]) + CW1'(1) >= CW1'(eff_limit_c)) begin
          out_d[i] = s_c[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin : state_ff
    if (!HRESETn) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < PORTWIDTH; i++) cnt_q[i] <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < PORTWIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign PORTIN_O = out_q;
  assign RISE     = rise_q;
  assign FALL     = fall_q;
  assign TICK     = tick_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed and randomized bench for gpio_input_conditioner against a cycle-level
// reference model built from the pin-level rules (history queue, integer counters).
module tb_gpio_input_conditioner;

  localparam int unsigned PW   = 16;
  localparam int unsigned CW   = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned PRW  = 16;

  logic            HCLK;
  logic            HRESETn;
  logic [PW-1:0]   PAD_IN;
  logic [PW-1:0]   DB_EN;
  logic [CW-1:0]   DB_LIMIT;
  logic [PRW-1:0]  PRESCALE;
  logic [PW-1:0]   PORTIN_O;
  logic [PW-1:0]   RISE;
  logic [PW-1:0]   FALL;
  logic            TICK;

  gpio_input_conditioner #(
    .PORTWIDTH(PW), .CNT_WIDTH(CW), .SYNC_STAGES(SYNC), .PRE_WIDTH(PRW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PAD_IN(PAD_IN), .DB_EN(DB_EN),
    .DB_LIMIT(DB_LIMIT), .PRESCALE(PRESCALE), .PORTIN_O(PORTIN_O),
    .RISE(RISE), .FALL(FALL), .TICK(TICK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit [PW-1:0] sq[$];
  int          ph;
  bit          tick_m;
  bit [PW-1:0] out_m, rise_m, fall_m;
  int          cnt_m [PW];

  task automatic model_reset();
    sq.delete();
    for (int k = 0; k < SYNC; k++) sq.push_back('0);
    ph = 0; tick_m = 0; out_m = '0; rise_m = '0; fall_m = '0;
    for (int i = 0; i < PW; i++) cnt_m[i] = 0;
  endtask

  // One active edge: inputs and model state are the values just before the edge.
  task automatic model_edge();
    bit [PW-1:0] s_old;
    bit [PW-1:0] nout;
    int          eff;
    s_old = sq[SYNC-1];
    nout  = out_m;
    eff   = (DB_LIMIT == 0) ? 1 : int'(DB_LIMIT);
    for (int i = 0; i < PW; i++) begin
      if (!DB_EN[i]) begin
        nout[i] = s_old[i]; cnt_m[i] = 0;
      end else if (s_old[i] == out_m[i]) begin
        cnt_m[i] = 0;
      end else if (tick_m) begin
        if (cnt_m[i] + 1 >= eff) begin nout[i] = s_old[i]; cnt_m[i] = 0; end
        else cnt_m[i] = cnt_m[i] + 1;
      end
    end
    rise_m = nout & ~out_m;
    fall_m = out_m & ~nout;
    out_m  = nout;
    sq.push_front(PAD_IN);
    void'(sq.pop_back());
    tick_m = (ph >= int'(PRESCALE));
    ph     = tick_m ? 0 : ph + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge HCLK);
    if (!HRESETn) model_reset(); else model_edge();
    #1;
    check("portin", PORTIN_O, out_m);
    check("rise", RISE, rise_m);
    check("fall", FALL, fall_m);
    check("tick", TICK, tick_m);
    check("rise_fall_excl", RISE & FALL, 0);
  endtask

  int ticks, fall_cnt;

  initial begin
    HRESETn = 1'b0; PAD_IN = 16'hFFFF; DB_EN = '0; DB_LIMIT = 8'd4; PRESCALE = '0;
    model_reset();

    // Reset with pads high, then release: unfiltered 3-edge latency
    repeat (3) cycle();
    check("rst_portin", PORTIN_O, 0);
    check("rst_rise", RISE, 0);
    check("rst_tick", TICK, 0);
    HRESETn = 1'b1;
    cycle(); cycle();
    check("rel_edge2", PORTIN_O, 0);
    cycle();
    check("rel_edge3", PORTIN_O, 16'hFFFF);
    check("rel_rise", RISE, 16'hFFFF);
    cycle();
    check("rel_rise_once", RISE, 0);

    // Filtered pin 0 (limit 4) alongside unfiltered pin 1
    PAD_IN = '0;
    repeat (6) cycle();
    DB_EN = 16'h0001; PAD_IN = 16'h0003;
    cycle(); cycle();
    check("db_edge2", PORTIN_O & 16'h3, 0);
    cycle();
    check("unf_lat3", PORTIN_O & 16'h3, 2);
    cycle(); cycle();
    check("db_edge5", PORTIN_O & 16'h1, 0);
    cycle();
    check("db_edge6", PORTIN_O & 16'h1, 1);
    check("db_rise", RISE & 16'h1, 1);
    cycle();
    check("db_rise_once", RISE & 16'h1, 0);

    // Bounce shorter than the limit is swallowed
    PAD_IN = 16'h0002;
    repeat (10) cycle();
    PAD_IN = 16'h0003;
    repeat (3) cycle();
    PAD_IN = 16'h0002;
    for (int n = 0; n < 11; n++) begin
      cycle();
      check("bounce_nopulse", (RISE | FALL) & 16'h1, 0);
    end
    check("bounce_out", PORTIN_O, 16'h0002);

    // Prescaled ticks, all pins filtered
    PRESCALE = 16'd9; DB_LIMIT = 8'd3; DB_EN = 16'hFFFF; PAD_IN = 16'h00F0;
    repeat (50) cycle();
    check("pre_settle", PORTIN_O, 16'h00F0);
    PAD_IN = '0; ticks = 0; fall_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      cycle();
      ticks += int'(TICK);
      if (FALL != '0) begin
        fall_cnt++;
        check("pre_fall_bits", FALL, 16'h00F0);
      end
    end
    check("pre_ticks", ticks, 4);
    check("pre_fall_once", fall_cnt, 1);
    check("pre_out", PORTIN_O, 0);

    // DB_LIMIT=0 acts as 1
    PRESCALE = '0; DB_LIMIT = '0;
    repeat (3) cycle();
    PAD_IN = 16'h0001;
    cycle(); cycle();
    check("lim0_edge2", PORTIN_O & 16'h1, 0);
    cycle();
    check("lim0_edge3", PORTIN_O & 16'h1, 1);
    check("lim0_rise", RISE & 16'h1, 1);

    // Reset in the middle of a count discards it
    DB_LIMIT = 8'd4; PAD_IN = '0;
    repeat (8) cycle();
    PAD_IN = 16'h0001;
    repeat (4) cycle();
    #2;
    HRESETn = 1'b0;
    model_reset();
    #1;
    check("midrst_out", PORTIN_O, 0);
    check("midrst_tick", TICK, 0);
    repeat (2) cycle();
    HRESETn = 1'b1;
    repeat (5) cycle();
    check("restart_edge5", PORTIN_O & 16'h1, 0);
    cycle();
    check("restart_edge6", PORTIN_O & 16'h1, 1);

    // Randomized segments with sparse pad activity
    for (int seg = 0; seg < 8; seg++) begin
      DB_EN    = 16'($urandom);
      DB_LIMIT = 8'($urandom_range(0, 5));
      PRESCALE = 16'($urandom_range(0, 4));
      for (int n = 0; n < 200; n++) begin
        PAD_IN ^= 16'($urandom & $urandom & $urandom & $urandom);
        if ($urandom_range(0, 49) == 0) PRESCALE = 16'($urandom_range(0, 4));
        if ($urandom_range(0, 99) == 0) DB_LIMIT = 8'($urandom_range(0, 5));
        if ($urandom_range(0, 99) == 0) DB_EN = 16'($urandom);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
